// File: rtl/xif_result_scheduler.sv
// Shares one eXtension-interface result channel among NUM_REQ coprocessor sources.
// Results are forwarded only once their id is committed; killed-id results are dropped.
module xif_result_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 64,
    parameter int RES_W       = X_ID_WIDTH + X_RFW_WIDTH + 5 + X_RFW_WIDTH/32 + 6 + 3 + 1 + 6 + 1 + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]      commit_id_i,
    input  logic                       commit_kill_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*RES_W-1:0]   req_result_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [RES_W-1:0]           result_o
);

    localparam int DEPTH = 2**X_ID_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [DEPTH-1:0]      cmt;
    logic [DEPTH-1:0]      kil;
    logic [DEPTH-1:0]      cmt_nxt;
    logic [DEPTH-1:0]      kil_nxt;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_nxt;

    logic [X_ID_WIDTH-1:0] src_id [NUM_REQ];
    logic [NUM_REQ-1:0]    src_cmt;
    logic [NUM_REQ-1:0]    src_kil;
    logic [NUM_REQ-1:0]    cand;

    logic                  out_free;
    logic                  win_valid;
    logic [PTR_W-1:0]      win_idx;
    logic                  win_kill;
    logic [X_ID_WIDTH-1:0] win_id;
    int                    idx;

    assign out_free = !result_valid_o || result_ready_i;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_src
        assign src_id[k]  = req_result_i[k*RES_W + RES_W - X_ID_WIDTH +: X_ID_WIDTH];
        assign src_cmt[k] = cmt[src_id[k]];
        assign src_kil[k] = kil[src_id[k]];
        // Drops need no output slot, so killed ids compete even while stalled.
        assign cand[k]    = req_valid_i[k] && (src_kil[k] || (src_cmt[k] && out_free));
    end

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_valid && cand[idx]) begin
                win_valid = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign win_id   = src_id[win_idx];
    assign win_kill = src_kil[win_idx];
    assign ptr_nxt  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (win_valid && !rst_i) req_ready_o[win_idx] = 1'b1;
    end

    // Clear first, then set, so a same-cycle commit to the cleared id survives.
    always_comb begin
        cmt_nxt = cmt;
        kil_nxt = kil;
        if (win_valid) begin
            if (win_kill) kil_nxt[win_id] = 1'b0;
            else          cmt_nxt[win_id] = 1'b0;
        end
        if (commit_valid_i) begin
            if (commit_kill_i) kil_nxt[commit_id_i] = 1'b1;
            else               cmt_nxt[commit_id_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmt            <= '0;
            kil            <= '0;
            ptr            <= '0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
        end else begin
            cmt <= cmt_nxt;
            kil <= kil_nxt;
            if (result_ready_i) result_valid_o <= 1'b0;
            if (win_valid) begin
                ptr <= ptr_nxt;
                if (!win_kill) begin
                    result_valid_o <= 1'b1;
                    result_o       <= req_result_i[win_idx*RES_W +: RES_W];
                end
            end
        end
    end

    a_commit_vs_clear: assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_valid_i && win_valid && commit_id_i == win_id));

    a_commit_flag_set: assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_valid_i && (cmt[commit_id_i] || kil[commit_id_i])));

endmodule

// File: tb/tb_xif_result_scheduler.sv
// Directed bench for xif_result_scheduler: commit gating, kill drops, round-robin,
// backpressure and mid-stream reset, with hand-computed expectations.
module tb_xif_result_scheduler;

    localparam int NUM_REQ = 4;
    localparam int XID     = 4;
    localparam int XRFW    = 64;
    localparam int RES_W   = XID + XRFW + 5 + XRFW/32 + 6 + 3 + 1 + 6 + 1 + 1;
    localparam int TAIL_W  = RES_W - XID - XRFW;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic                     commit_valid_i;
    logic [XID-1:0]           commit_id_i;
    logic                     commit_kill_i;
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*RES_W-1:0] req_result_i;
    logic                     result_valid_o;
    logic                     result_ready_i;
    logic [RES_W-1:0]         result_o;

    int checks   = 0;
    int failures = 0;

    xif_result_scheduler #(.NUM_REQ(NUM_REQ), .X_ID_WIDTH(XID), .X_RFW_WIDTH(XRFW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_result_i   (req_result_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] mk(input logic [XID-1:0] id, input logic [XRFW-1:0] data);
        logic [TAIL_W-1:0] t;
        t = TAIL_W'(32'h0A5A5A0) ^ TAIL_W'(id);
        return {id, data, t};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [XID-1:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic present(input int k, input logic [XID-1:0] id, input logic [XRFW-1:0] data);
        req_result_i[k*RES_W +: RES_W] = mk(id, data);
        req_valid_i[k] = 1'b1;
    endtask

    initial begin
        rst_i          = 1'b1;
        commit_valid_i = 1'b0;
        commit_id_i    = '0;
        commit_kill_i  = 1'b0;
        req_valid_i    = '0;
        req_result_i   = '0;
        result_ready_i = 1'b1;
        tick();
        tick();
        chk("reset_valid", 128'(result_valid_o), 128'(0));
        chk("reset_result", 128'(result_o), 128'(0));
        chk("reset_ready", 128'(req_ready_o), 128'(0));
        rst_i = 1'b0;
        tick();

        // single source, already committed: grant same cycle, output next cycle
        commit(4'd3, 1'b0);
        present(0, 4'd3, 64'h0000_0001_DEAD_BEEF);
        settle();
        chk("single_grant", 128'(req_ready_o), 128'(4'b0001));
        tick();
        chk("single_valid", 128'(result_valid_o), 128'(1));
        chk("single_payload", 128'(result_o), 128'(mk(4'd3, 64'h0000_0001_DEAD_BEEF)));
        settle();
        chk("single_cmt_cleared", 128'(req_ready_o), 128'(0));
        req_valid_i = '0;
        tick();
        chk("single_valid_drop", 128'(result_valid_o), 128'(0));

        // result waits for its commit
        present(1, 4'd5, 64'h5555_0000_1234_5678);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("wait_no_grant", 128'(req_ready_o), 128'(0));
            tick();
        end
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd5;
        settle();
        chk("wait_commit_cycle", 128'(req_ready_o), 128'(0));
        tick();
        commit_valid_i = 1'b0;
        settle();
        chk("wait_grant_t1", 128'(req_ready_o), 128'(4'b0010));
        chk("wait_valid_t1", 128'(result_valid_o), 128'(0));
        tick();
        req_valid_i = '0;
        chk("wait_valid_t2", 128'(result_valid_o), 128'(1));
        chk("wait_payload", 128'(result_o), 128'(mk(4'd5, 64'h5555_0000_1234_5678)));
        tick();

        // kill: dropped, output untouched, flag cleared
        commit(4'd7, 1'b1);
        present(2, 4'd7, 64'h7777);
        settle();
        chk("kill_drop", 128'(req_ready_o), 128'(4'b0100));
        tick();
        chk("kill_no_output", 128'(result_valid_o), 128'(0));
        settle();
        chk("kill_cleared", 128'(req_ready_o), 128'(0));
        req_valid_i = '0;
        // one more drop on source 3 brings the pointer back to 0
        commit(4'd8, 1'b1);
        present(3, 4'd8, 64'h8888);
        settle();
        chk("kill_src3", 128'(req_ready_o), 128'(4'b1000));
        tick();
        req_valid_i = '0;

        // round robin from ptr=0
        for (int k = 0; k < 4; k++) commit(4'(k + 1), 1'b0);
        for (int k = 0; k < 4; k++) present(k, 4'(k + 1), 64'hA000 + 64'(k));
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("rr0_grant", 128'(req_ready_o), 128'(4'b0001 << j));
            tick();
            req_valid_i[j] = 1'b0;
            chk("rr0_payload", 128'(result_o), 128'(mk(4'(j + 1), 64'hA000 + 64'(j))));
        end
        tick();
        chk("rr0_idle", 128'(result_valid_o), 128'(0));

        // move pointer to 2 with two drops
        commit(4'd9, 1'b1);
        commit(4'd10, 1'b1);
        present(0, 4'd9, 64'h9);
        present(1, 4'd10, 64'hA);
        settle();
        chk("ptr_drop0", 128'(req_ready_o), 128'(4'b0001));
        tick();
        req_valid_i[0] = 1'b0;
        settle();
        chk("ptr_drop1", 128'(req_ready_o), 128'(4'b0010));
        tick();
        req_valid_i[1] = 1'b0;

        // round robin from ptr=2: 2,3,0,1
        for (int k = 0; k < 4; k++) commit(4'(k + 1), 1'b0);
        for (int k = 0; k < 4; k++) present(k, 4'(k + 1), 64'hB000 + 64'(k));
        for (int j = 0; j < 4; j++) begin
            int g;
            g = (j + 2) % 4;
            settle();
            chk("rr2_grant", 128'(req_ready_o), 128'(4'b0001 << g));
            tick();
            req_valid_i[g] = 1'b0;
            chk("rr2_payload", 128'(result_o), 128'(mk(4'(g + 1), 64'hB000 + 64'(g))));
        end
        tick();

        // backpressure; ptr=2 here
        commit(4'd11, 1'b0);
        commit(4'd12, 1'b0);
        commit(4'd13, 1'b1);
        result_ready_i = 1'b0;
        present(0, 4'd11, 64'hC0);
        present(1, 4'd12, 64'hC1);
        settle();
        chk("bp_first_grant", 128'(req_ready_o), 128'(4'b0001));
        tick();
        req_valid_i[0] = 1'b0;
        present(3, 4'd13, 64'hC3);
        settle();
        chk("bp_kill_while_stalled", 128'(req_ready_o), 128'(4'b1000));
        chk("bp_payload", 128'(result_o), 128'(mk(4'd11, 64'hC0)));
        tick();
        req_valid_i[3] = 1'b0;
        settle();
        chk("bp_no_second_grant", 128'(req_ready_o), 128'(0));
        chk("bp_valid_held", 128'(result_valid_o), 128'(1));
        chk("bp_payload_stable", 128'(result_o), 128'(mk(4'd11, 64'hC0)));
        result_ready_i = 1'b1;
        settle();
        chk("bp_release_grant", 128'(req_ready_o), 128'(4'b0010));
        tick();
        req_valid_i[1] = 1'b0;
        result_ready_i = 1'b0;
        chk("bp_second_payload", 128'(result_o), 128'(mk(4'd12, 64'hC1)));

        // reset mid-stream with output valid and id 14 committed
        commit(4'd14, 1'b0);
        chk("rst_pre_valid", 128'(result_valid_o), 128'(1));
        rst_i = 1'b1;
        present(0, 4'd14, 64'hE0);
        settle();
        chk("rst_ready_gated", 128'(req_ready_o), 128'(0));
        tick();
        rst_i = 1'b0;
        result_ready_i = 1'b1;
        settle();
        chk("rst_valid", 128'(result_valid_o), 128'(0));
        chk("rst_result", 128'(result_o), 128'(0));
        chk("rst_cmt_lost", 128'(req_ready_o), 128'(0));
        tick();
        chk("rst_still_waiting", 128'(req_ready_o), 128'(0));
        commit(4'd14, 1'b0);
        settle();
        chk("rst_recommit_grant", 128'(req_ready_o), 128'(4'b0001));
        tick();
        req_valid_i = '0;
        chk("rst_recommit_payload", 128'(result_o), 128'(mk(4'd14, 64'hE0)));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
